// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared types and constants for the iterative multiply/divide unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = $clog2(MDU_ITER);

  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_core.sv
// ============================================================================
// mdu_div_core : restoring divider, one quotient bit per enabled cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo_nxt,
  output logic [WIDTH-1:0] o_rem_nxt
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  // The partial remainder is WIDTH+1 bits wide only after the shift; once the
  // trial subtraction succeeds it is again below the divisor and fits WIDTH.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_sub     = w_shift[WIDTH-1:0] - r_div;
  assign o_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
  assign o_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
    end else if (i_en) begin
      r_quo <= o_quo_nxt;
      r_rem <= o_rem_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Build option: MDU_FAST_MUL_EN gives single-cycle combinational multiplies.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t             r_state;
  logic [MDU_CNT_W-1:0]   r_cnt;
  logic                   r_is_mul;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic                   r_dz;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_mcand;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  mdu_op_t                w_op;
  logic                   w_sgn;
  logic                   w_s1;
  logic                   w_s2;
  logic [WIDTH-1:0]       w_mag1;
  logic [WIDTH-1:0]       w_mag2;
  logic                   w_is_mul_in;
  logic                   w_can_launch;
  logic                   w_fast_go;
  logic [2*WIDTH-1:0]     w_fast_prod;
  logic                   w_last;
  logic [WIDTH:0]         w_mul_sum;
  logic [2*WIDTH-1:0]     w_acc_nxt;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo_nxt;
  logic [WIDTH-1:0]       w_rem_nxt;
  logic [WIDTH-1:0]       w_div_hi;
  logic [WIDTH-1:0]       w_div_lo;
  logic [WIDTH-1:0]       w_res_hi;
  logic [WIDTH-1:0]       w_res_lo;

  // Launch decode: operands reduced to magnitudes plus sign flags.
  assign w_op         = mdu_op_t'(op);
  assign w_sgn        = is_signed_op(w_op);
  assign w_s1         = w_sgn & Data1[WIDTH-1];
  assign w_s2         = w_sgn & Data2[WIDTH-1];
  assign w_mag1       = w_s1 ? (~Data1 + 1'b1) : Data1;
  assign w_mag2       = w_s2 ? (~Data2 + 1'b1) : Data2;
  assign w_is_mul_in  = ~op[1];
  assign w_can_launch = start && (r_state != RUN);

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_mag;
  assign w_fast_mag  = {{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2};
  assign w_fast_prod = (w_s1 ^ w_s2) ? (~w_fast_mag + 1'b1) : w_fast_mag;
  assign w_fast_go   = w_can_launch & w_is_mul_in;
`else
  assign w_fast_prod = '0;
  assign w_fast_go   = 1'b0;
`endif

  // Shift-add step: add multiplicand into the upper half when LSB set, then
  // shift the whole 65-bit {carry, acc} right by one.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_can_launch & ~w_fast_go),
    .i_en      ((r_state == RUN) & ~r_is_mul),
    .i_dividend(w_mag1),
    .i_divisor (w_mag2),
    .o_quo_nxt (w_quo_nxt),
    .o_rem_nxt (w_rem_nxt)
  );

  // Final results are taken from the last step's next values so HI/LO load
  // on the same edge that enters DONE.
  assign w_last   = (r_state == RUN) && (r_cnt == MDU_CNT_W'(MDU_ITER - 1));
  assign w_prod   = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_div_lo = r_dz ? {WIDTH{1'b1}}
                         : (r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt);
  // With a zero divisor the remainder path reproduces the dividend exactly.
  assign w_div_hi = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
  assign w_res_hi = r_is_mul ? w_prod[2*WIDTH-1:WIDTH] : w_div_hi;
  assign w_res_lo = r_is_mul ? w_prod[WIDTH-1:0]       : w_div_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (r_is_mul) begin
            r_acc <= w_acc_nxt;
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end
        end
        default: begin
          if (hi_we) begin
            r_hi <= wdata;
          end
          if (lo_we) begin
            r_lo <= wdata;
          end
          // Later assignments override the MTHI/MTLO writes above.
          if (w_fast_go) begin
            r_state <= DONE;
            r_hi    <= w_fast_prod[2*WIDTH-1:WIDTH];
            r_lo    <= w_fast_prod[WIDTH-1:0];
          end else if (start) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_is_mul <= w_is_mul_in;
            r_neg_q  <= w_s1 ^ w_s2;
            r_neg_r  <= w_s1 & ~w_is_mul_in;
            r_dz     <= (Data2 == '0);
            r_acc    <= {{WIDTH{1'b0}}, w_mag2};
            r_mcand  <= w_mag1;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire
